exu_div_core: RTL and testbench

//  Responder side of the execute-stage divide handshake: iterative radix-2 restoring divider.

---
 rtl/exu_div_core_pkg.sv | 17 +
 rtl/exu_div_core_if.sv | 24 ++
 rtl/exu_div_core_step.sv | 26 ++
 rtl/exu_div_core.sv | 137 +++++++++++++
 tb/tb_exu_div_core.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_div_core_pkg.sv
// Shared types and op-bit indices for the execute-stage divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

  // Bit positions inside the one-hot op_i vector.
  localparam int DIV_OP_DIV  = 3;
  localparam int DIV_OP_DIVU = 2;
  localparam int DIV_OP_REM  = 1;
  localparam int DIV_OP_REMU = 0;
  localparam int DIV_OP_W    = 4;

endpackage

// File: rtl/exu_div_core_if.sv
// Divide request/response bundle between the muldiv unit (master) and the divider (slave).
interface exu_div_core_if
  import div_pkg::*;
#(
  parameter int DW = 32
);
  logic [DW-1:0]       dividend_i;
  logic [DW-1:0]       divisor_i;
  logic                start_i;
  logic [DIV_OP_W-1:0] op_i;
  logic [DW-1:0]       result_o;
  logic                ready_o;
  logic                busy_o;

  modport master (
    output dividend_i, divisor_i, start_i, op_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  dividend_i, divisor_i, start_i, op_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/exu_div_core_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_rem,
  input  logic [DW-1:0] i_quo,
  input  logic [DW-1:0] i_divisor,
  output logic [DW-1:0] o_rem,
  output logic [DW-1:0] o_quo
);
  // One extra bit keeps the shifted remainder exact when the divisor exceeds 2^(DW-1).
  logic [DW:0] w_shift;
  logic [DW:0] w_diff;

  assign w_shift = {i_rem, i_quo[DW-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  always_comb begin
    o_quo = {i_quo[DW-2:0], 1'b0};
    o_rem = w_shift[DW-1:0];
    if (!w_diff[DW]) begin
      o_rem    = w_diff[DW-1:0];
      o_quo[0] = 1'b1;
    end
  end
endmodule

// File: rtl/exu_div_core.sv
// Iterative restoring divider serving DIV/DIVU/REM/REMU behind a level-held start handshake.
// state    | meaning
// DIV_IDLE | waiting for start_i with a legal op
// DIV_CALC | one quotient bit per cycle, DW cycles
// DIV_DONE | ready_o/result_o valid for this single cycle
module exu_div_core
  import div_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  exu_div_core_if.slave  div_if
);
  localparam int CW = $clog2(DW) + 1;

  div_state_e    r_state;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_quo;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_divisor;
  logic [DW-1:0] r_result;
  logic          r_sel_quo;
  logic          r_sign_dvd;
  logic          r_sign_dvs;
  logic          r_ready;
  logic          r_busy;

  logic          w_signed;
  logic          w_dvd_neg;
  logic          w_dvs_neg;
  logic [DW-1:0] w_dvd_abs;
  logic [DW-1:0] w_dvs_abs;
  logic [DW-1:0] w_dvz_result;
  logic [DW-1:0] w_rem_nxt;
  logic [DW-1:0] w_quo_nxt;
  logic [DW-1:0] w_quo_fix;
  logic [DW-1:0] w_rem_fix;
  logic [DW-1:0] w_final;

  assign w_signed  = div_if.op_i[DIV_OP_DIV] | div_if.op_i[DIV_OP_REM];
  assign w_dvd_neg = w_signed & div_if.dividend_i[DW-1];
  assign w_dvs_neg = w_signed & div_if.divisor_i[DW-1];
  assign w_dvd_abs = w_dvd_neg ? -div_if.dividend_i : div_if.dividend_i;
  assign w_dvs_abs = w_dvs_neg ? -div_if.divisor_i  : div_if.divisor_i;

  // Divide-by-zero returns the raw dividend for remainders, all ones for quotients.
  assign w_dvz_result = (div_if.op_i[DIV_OP_DIV] | div_if.op_i[DIV_OP_DIVU]) ?
                        {DW{1'b1}} : div_if.dividend_i;

  div_step #(.DW(DW)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  // Sign flags are only ever set for signed ops, so unsigned ops pass through untouched.
  assign w_quo_fix = (r_sign_dvd != r_sign_dvs) ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = r_sign_dvd ? -w_rem_nxt : w_rem_nxt;
  assign w_final   = r_sel_quo ? w_quo_fix : w_rem_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DIV_IDLE;
      r_count    <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_result   <= '0;
      r_sel_quo  <= 1'b0;
      r_sign_dvd <= 1'b0;
      r_sign_dvs <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (div_if.start_i && (|div_if.op_i)) begin
            r_sel_quo  <= div_if.op_i[DIV_OP_DIV] | div_if.op_i[DIV_OP_DIVU];
            r_sign_dvd <= w_dvd_neg;
            r_sign_dvs <= w_dvs_neg;
            r_count    <= '0;
            r_busy     <= 1'b1;
            if (div_if.divisor_i == '0) begin
              r_state  <= DIV_DONE;
              r_ready  <= 1'b1;
              r_result <= w_dvz_result;
            end else begin
              r_state   <= DIV_CALC;
              r_quo     <= w_dvd_abs;
              r_rem     <= '0;
              r_divisor <= w_dvs_abs;
            end
          end
        end
        DIV_CALC: begin
          if (!div_if.start_i) begin
            r_state <= DIV_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_quo   <= w_quo_nxt;
            r_rem   <= w_rem_nxt;
            r_count <= r_count + CW'(1);
            if (r_count == CW'(DW - 1)) begin
              r_state  <= DIV_DONE;
              r_ready  <= 1'b1;
              r_result <= w_final;
            end
          end
        end
        DIV_DONE: begin
          r_state  <= DIV_IDLE;
          r_ready  <= 1'b0;
          r_result <= '0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state  <= DIV_IDLE;
          r_ready  <= 1'b0;
          r_result <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.result_o = r_result;
  assign div_if.ready_o  = r_ready;
  assign div_if.busy_o   = r_busy;

  // More than one op bit on an accepted request is a caller bug.
  a_op_onehot: assert property (@(posedge clk) disable iff (rst)
    (r_state == DIV_IDLE && div_if.start_i) |-> $onehot0(div_if.op_i));

endmodule

// File: tb/tb_exu_div_core.sv
// Self-checking bench for exu_div_core: directed corner cases plus random ops vs an arithmetic model.
module tb_exu_div_core;
  import div_pkg::*;

  localparam int DW = 32;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REM  = 4'b0010;
  localparam logic [3:0] OP_REMU = 4'b0001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  exu_div_core_if #(.DW(DW)) dif ();

  exu_div_core #(.DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V divide semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return (op[3] | op[2]) ? 32'hFFFF_FFFF : a;
    if (op[3] | op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[3] ? 32'(sa / sb) : 32'(sa % sb);
    end
    return op[2] ? (a / b) : (a % b);
  endfunction

  // Issue one request, hold start until ready_o, drop it in the ready cycle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, output logic [31:0] res, output int lat,
                       output int n_bad);
    @(posedge clk);
    #1;
    dif.start_i    = 1'b1;
    dif.op_i       = op;
    dif.dividend_i = a;
    dif.divisor_i  = b;
    lat   = -1;
    res   = '0;
    n_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dif.ready_o) begin
        lat = k;
        res = dif.result_o;
        dif.start_i = 1'b0;
        break;
      end
      if (dif.result_o !== 32'd0) n_bad++;
      if (scramble && k >= 1) begin
        dif.dividend_i = $urandom;
        dif.divisor_i  = $urandom;
        dif.op_i       = 4'b0001 << $urandom_range(0, 3);
      end
      @(posedge clk);
    end
    if (lat < 0) dif.start_i = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int lat, n_bad;
    do_op(op, a, b, 1'b0, res, lat, n_bad);
    n_checks++;
    if (res !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", name, res, exp_res);
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (n_bad !== 0) begin
      n_fail++;
      $display("FAIL %s idle_result: got %0d nonzero cycles expected 0", name, n_bad);
    end
  endtask

  task automatic test_reset();
    bit moved;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dif.result_o !== 32'd0) begin
      n_fail++; $display("FAIL reset result: got %h expected 0", dif.result_o);
    end
    n_checks++;
    if (dif.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset ready: got %b expected 0", dif.ready_o);
    end
    n_checks++;
    if (dif.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset busy: got %b expected 0", dif.busy_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    // start with no op bit must be ignored
    dif.start_i = 1'b1;
    dif.op_i    = 4'b0000;
    dif.divisor_i = 32'd0;
    moved = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (dif.busy_o !== 1'b0 || dif.ready_o !== 1'b0) moved = 1'b1;
    end
    dif.start_i = 1'b0;
    n_checks++;
    if (moved) begin
      n_fail++; $display("FAIL zero_op: got activity expected idle");
    end
  endtask

  task automatic test_basic();
    check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
  endtask

  task automatic test_signed();
    check_op("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    check_op("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    check_op("remu_fff9", OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
  endtask

  task automatic test_div_zero();
    check_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    check_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
  endtask

  task automatic test_overflow();
    check_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    check_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
  endtask

  task automatic test_abort();
    bit saw_ready;
    @(posedge clk);
    #1;
    dif.start_i    = 1'b1;
    dif.op_i       = OP_DIVU;
    dif.dividend_i = 32'd50;
    dif.divisor_i  = 32'd7;
    saw_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dif.ready_o) saw_ready = 1'b1;
      @(posedge clk);
    end
    #1 dif.start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dif.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL abort busy_c10: got %b expected 1", dif.busy_o);
    end
    @(negedge clk);
    n_checks++;
    if (dif.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL abort busy_c11: got %b expected 0", dif.busy_o);
    end
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o || dif.result_o !== 32'd0) saw_ready = 1'b1;
    end
    n_checks++;
    if (saw_ready) begin
      n_fail++; $display("FAIL abort ready: got pulse expected none");
    end
    check_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);
  endtask

  task automatic test_reset_mid();
    bit saw_ready;
    @(posedge clk);
    #1;
    dif.start_i    = 1'b1;
    dif.op_i       = OP_DIVU;
    dif.dividend_i = 32'd1000;
    dif.divisor_i  = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    dif.start_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) saw_ready = 1'b1;
    end
    n_checks++;
    if (saw_ready) begin
      n_fail++; $display("FAIL rst_mid ready: got pulse expected none");
    end
    n_checks++;
    if (dif.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid busy: got %b expected 0", dif.busy_o);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_divu", OP_DIVU, 32'd10, 32'd3, 32'd3, 33);
    check_op("b2b_remu", OP_REMU, 32'd10, 32'd3, 32'd1, 33);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, res, exp;
    int lat, n_bad, exp_lat, errs, bad_total;
    errs = 0;
    bad_total = 0;
    for (int i = 0; i < 1500; i++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 16));
        3: b = b | 32'h8000_0000;
        4: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      exp     = ref_div(op, a, b);
      exp_lat = (b == 32'd0) ? 1 : 33;
      do_op(op, a, b, 1'b1, res, lat, n_bad);
      bad_total += n_bad;
      n_checks++;
      if (res !== exp || lat !== exp_lat) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random op=%b a=%h b=%h: got %h lat %0d expected %h lat %0d",
                   op, a, b, res, lat, exp, exp_lat);
      end
    end
    n_checks++;
    if (bad_total !== 0) begin
      n_fail++; $display("FAIL random idle_result: got %0d nonzero cycles expected 0", bad_total);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    dif.start_i    = 1'b0;
    dif.op_i       = 4'b0000;
    dif.dividend_i = 32'd0;
    dif.divisor_i  = 32'd0;
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
